// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-like request arbiter with in-order response routing.
// Optional round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
module sram_req_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int PtrW = $clog2(OT_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic {
    LockIdle   = 1'b0,
    LockHeld   = 1'b1
  } lock_state_e;

  lock_state_e           lock_q;
  logic                  lockedOwner_q;
  logic                  rr_q;
  logic [OT_DEPTH-1:0]   fifo_q;
  logic [PtrW-1:0]       wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]       rdPtr_q, rdPtr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic full;
  logic candI, candD;
  logic winner;
  logic owner;
  logic ownerReq;
  logic accept;
  logic pop;
  logic headOwner;

  assign full  = (count_q == CntW'(OT_DEPTH));
  assign candI = i_req && !full;
  assign candD = d_req && !full;

  // Owner id: 0 = inst, 1 = data. With no candidate the winner is don't-care.
  always_comb begin
    winner = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (candI && candD) winner = rr_q;
    else                winner = candD;
`else
    winner = candD;
`endif
  end

  assign owner    = (lock_q == LockHeld) ? lockedOwner_q : winner;
  assign ownerReq = owner ? d_req : i_req;
  assign m_req    = resetn && ownerReq && !full;
  assign accept   = m_req && m_addr_ok;

  assign m_wr    = owner ? d_wr    : 1'b0;
  assign m_size  = owner ? d_size  : 2'd2;
  assign m_wstrb = owner ? d_wstrb : 4'h0;
  assign m_addr  = owner ? d_addr  : i_addr;
  assign m_wdata = owner ? d_wdata : 32'h0;

  assign i_addr_ok = accept && !owner;
  assign d_addr_ok = accept &&  owner;

  // Responses arrive in acceptance order, so the FIFO head names the requester.
  assign pop       = resetn && m_data_ok && (count_q != '0);
  assign headOwner = fifo_q[rdPtr_q];
  assign i_data_ok = pop && !headOwner;
  assign d_data_ok = pop &&  headOwner;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (accept) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)    rdPtr_d = rdPtr_q + 1'b1;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      fifo_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (accept) fifo_q[wrPtr_q] <= owner;
    end
  end

  // A presented but unaccepted request keeps its owner until the handshake ends.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q        <= LockIdle;
      lockedOwner_q <= 1'b0;
      rr_q          <= 1'b0;
    end else begin
      case (lock_q)
        LockIdle: begin
          if (m_req && !m_addr_ok) begin
            lock_q        <= LockHeld;
            lockedOwner_q <= owner;
          end
        end
        LockHeld: begin
          if (accept) lock_q <= LockIdle;
        end
        default: lock_q <= LockIdle;
      endcase
      if (accept) rr_q <= ~owner;
    end
  end

endmodule
